// File: rtl/fetch_pkg.sv
// Shared defaults and FSM state encoding for the instruction fetch controller.
package fetch_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int INSTR_WIDTH_DEF = 8;
    localparam int PC_STEP_DEF     = 2;
    localparam int RESET_PC_DEF    = 'h00;
    localparam int HALT_INSTR_DEF  = 'hFF;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

endpackage

// File: rtl/fetch_pc_register.sv
// Program counter: synchronous reset, aligned load, wrapping increment, hold.
module pc_register
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int                    PC_STEP    = PC_STEP_DEF,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [ADDR_WIDTH-1:0] load_addr_i,
    input  logic                  inc_i,
    output logic [ADDR_WIDTH-1:0] pc_o
);

    logic [ADDR_WIDTH-1:0] pc_q;
    logic [ADDR_WIDTH-1:0] pc_d;

    // Load wins over increment; the LSB is forced low so fetches stay aligned.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = {load_addr_i[ADDR_WIDTH-1:1], 1'b0};
        end else if (inc_i) begin
            pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_controller.sv
// Fetch stage: owns the PC, captures memory data into a one-entry output
// register and hands it to decode with valid/ready (transfer when both high).
module fetch_controller
    import fetch_pkg::*;
#(
    parameter int                     ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int                     INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int                     PC_STEP     = PC_STEP_DEF,
    parameter logic [ADDR_WIDTH-1:0]  RESET_PC    = ADDR_WIDTH'(RESET_PC_DEF),
    parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = INSTR_WIDTH'(HALT_INSTR_DEF)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_start,
    output logic [ADDR_WIDTH-1:0]  pc_address,
    input  logic [INSTR_WIDTH-1:0] in_instruction,
    output logic [INSTR_WIDTH-1:0] out_instruction,
    output logic [ADDR_WIDTH-1:0]  out_instr_pc,
    output logic                   out_valid,
    input  logic                   in_ready,
    input  logic                   in_redirect,
    input  logic [ADDR_WIDTH-1:0]  in_redirect_addr,
    output logic                   out_align_err,
    output logic                   out_halted,
    output logic                   out_busy,
    output logic [1:0]             dbg_state
);

    logic [1:0]             state_q, state_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic [ADDR_WIDTH-1:0]  ipc_q, ipc_d;
    logic                   valid_q, valid_d;
    logic                   align_q, align_d;
    logic                   busy_q, halted_q;
    logic                   pc_load, pc_inc, capture;
    logic [ADDR_WIDTH-1:0]  pc;

    pc_register #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .PC_STEP    (PC_STEP),
        .RESET_PC   (RESET_PC)
    ) u_pc (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_i      (pc_load),
        .load_addr_i (in_redirect_addr),
        .inc_i       (pc_inc),
        .pc_o        (pc)
    );

    assign capture = (state_q == ST_FETCH) && (!valid_q || in_ready);

    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        align_d = 1'b0;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        if (in_redirect) begin
            // Flush the pending word even if decode is taking it this cycle.
            pc_load = 1'b1;
            valid_d = 1'b0;
            state_d = ST_FETCH;
            align_d = in_redirect_addr[0];
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (valid_q && in_ready) valid_d = 1'b0;
                    if (in_start) state_d = ST_FETCH;
                end
                ST_FETCH: begin
                    if (capture) begin
                        instr_d = in_instruction;
                        ipc_d   = pc;
                        valid_d = 1'b1;
                        if (in_instruction == HALT_INSTR) begin
                            state_d = ST_HALT;
                        end else begin
                            pc_inc = 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (valid_q && in_ready) valid_d = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            instr_q  <= '0;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            align_q  <= 1'b0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            align_q  <= align_d;
            busy_q   <= (state_d == ST_FETCH);
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign pc_address      = pc;
    assign out_instruction = instr_q;
    assign out_instr_pc    = ipc_q;
    assign out_valid       = valid_q;
    assign out_align_err   = align_q;
    assign out_busy        = busy_q;
    assign out_halted      = halted_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller against a small combinational program memory.
module tb_fetch_controller;
    import fetch_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_start;
    logic [7:0] pc_address;
    logic [7:0] in_instruction;
    logic [7:0] out_instruction;
    logic [7:0] out_instr_pc;
    logic       out_valid;
    logic       in_ready;
    logic       in_redirect;
    logic [7:0] in_redirect_addr;
    logic       out_align_err;
    logic       out_halted;
    logic       out_busy;
    logic [1:0] dbg_state;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_read(input logic [7:0] a);
        case (a)
            8'h00:   return 8'h11;
            8'h02:   return 8'h22;
            8'h04:   return 8'h33;
            8'h06:   return 8'hFF;
            default: return 8'h00;
        endcase
    endfunction

    assign in_instruction = mem_read(pc_address);

    fetch_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .in_start         (in_start),
        .pc_address       (pc_address),
        .in_instruction   (in_instruction),
        .out_instruction  (out_instruction),
        .out_instr_pc     (out_instr_pc),
        .out_valid        (out_valid),
        .in_ready         (in_ready),
        .in_redirect      (in_redirect),
        .in_redirect_addr (in_redirect_addr),
        .out_align_err    (out_align_err),
        .out_halted       (out_halted),
        .out_busy         (out_busy),
        .dbg_state        (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [7:0] ins, input logic [7:0] ipc,
                           input logic vld, input logic [7:0] pc);
        check({tag, ".instr"}, 32'(out_instruction), 32'(ins));
        check({tag, ".ipc"},   32'(out_instr_pc),    32'(ipc));
        check({tag, ".valid"}, 32'(out_valid),       32'(vld));
        check({tag, ".pc"},    32'(pc_address),      32'(pc));
    endtask

    initial begin
        rst_n = 1'b0; in_start = 1'b0; in_ready = 1'b0;
        in_redirect = 1'b0; in_redirect_addr = 8'h00;
        step(); step();
        chk_out("reset", 8'h00, 8'h00, 1'b0, 8'h00);
        check("reset.busy",   32'(out_busy),      32'd0);
        check("reset.halted", 32'(out_halted),    32'd0);
        check("reset.align",  32'(out_align_err), 32'd0);
        check("reset.state",  32'(dbg_state),     32'(ST_IDLE));
        rst_n = 1'b1;
        step();
        check("idle.pc_held", 32'(pc_address), 32'h00);

        // Start: no capture on the start edge, then one word per cycle.
        in_start = 1'b1;
        step();
        in_start = 1'b0;
        check("start.busy", 32'(out_busy), 32'd1);
        check("start.valid", 32'(out_valid), 32'd0);
        in_ready = 1'b1;
        step(); chk_out("seq0", 8'h11, 8'h00, 1'b1, 8'h02);
        step(); chk_out("seq1", 8'h22, 8'h02, 1'b1, 8'h04);
        step(); chk_out("seq2", 8'h33, 8'h04, 1'b1, 8'h06);
        step(); chk_out("seq3", 8'hFF, 8'h06, 1'b1, 8'h06);
        check("seq3.halted", 32'(out_halted), 32'd1);
        check("seq3.busy",   32'(out_busy),   32'd0);
        step(); chk_out("drain", 8'hFF, 8'h06, 1'b0, 8'h06);

        // Halt: start ignored.
        in_start = 1'b1;
        step(); check("halt_start0", 32'(out_halted), 32'd1);
        step(); check("halt_start1", 32'(out_halted), 32'd1);
        check("halt_start.pc", 32'(pc_address), 32'h06);
        check("halt_start.valid", 32'(out_valid), 32'd0);
        in_start = 1'b0;

        // Halt exit by redirect to 0.
        in_redirect = 1'b1; in_redirect_addr = 8'h00;
        step();
        in_redirect = 1'b0;
        check("hexit.busy", 32'(out_busy), 32'd1);
        check("hexit.align", 32'(out_align_err), 32'd0);
        chk_out("hexit", 8'hFF, 8'h06, 1'b0, 8'h00);
        step(); chk_out("hexit1", 8'h11, 8'h00, 1'b1, 8'h02);
        step(); chk_out("hexit2", 8'h22, 8'h02, 1'b1, 8'h04);

        // Stall with 22 held.
        in_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(); chk_out($sformatf("stall%0d", i), 8'h22, 8'h02, 1'b1, 8'h04);
        end
        in_ready = 1'b1;
        step(); chk_out("unstall", 8'h33, 8'h04, 1'b1, 8'h06);
        step(); chk_out("unstall.ff", 8'hFF, 8'h06, 1'b1, 8'h06);

        // Back to 22 and stall, then redirect to odd target 05.
        in_redirect = 1'b1; in_redirect_addr = 8'h00;
        step();
        in_redirect = 1'b0;
        step(); step();
        in_ready = 1'b0;
        chk_out("pre_redir", 8'h22, 8'h02, 1'b1, 8'h04);
        in_redirect = 1'b1; in_redirect_addr = 8'h05;
        step();
        in_redirect = 1'b0;
        chk_out("redir", 8'h22, 8'h02, 1'b0, 8'h04);
        check("redir.align", 32'(out_align_err), 32'd1);
        step(); chk_out("redir1", 8'h33, 8'h04, 1'b1, 8'h06);
        check("redir1.align", 32'(out_align_err), 32'd0);
        in_ready = 1'b1;
        step(); chk_out("redir2", 8'hFF, 8'h06, 1'b1, 8'h06);

        // Wrap: redirect to FE while FF is being accepted (flushed).
        in_redirect = 1'b1; in_redirect_addr = 8'hFE;
        step();
        in_redirect = 1'b0;
        chk_out("wrap0", 8'hFF, 8'h06, 1'b0, 8'hFE);
        step(); chk_out("wrap1", 8'h00, 8'hFE, 1'b1, 8'h00);
        step(); chk_out("wrap2", 8'h11, 8'h00, 1'b1, 8'h02);

        // Reset mid-stream.
        rst_n = 1'b0;
        step();
        chk_out("midrst", 8'h00, 8'h00, 1'b0, 8'h00);
        check("midrst.state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst.busy",  32'(out_busy),  32'd0);
        rst_n = 1'b1;
        step();

        // Start and redirect together in IDLE: redirect target wins.
        in_start = 1'b1; in_redirect = 1'b1; in_redirect_addr = 8'h04;
        step();
        in_start = 1'b0; in_redirect = 1'b0;
        check("both.pc",   32'(pc_address), 32'h04);
        check("both.busy", 32'(out_busy),   32'd1);
        step(); chk_out("both1", 8'h33, 8'h04, 1'b1, 8'h06);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
